// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, drives combinational IM address, and queues {pc, instr} for decode.
// Optional feature macro: FETCH_HALT_EN (stop fetching after an opcode-F word until redirect).
module fetch_queue #(
   parameter int          DEPTH    = 2,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_f,
   output logic [15:0] im_addr,
   input  logic [31:0] im_data,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [15:0] out_pc,
   output logic        halted
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {RUN, HALT} state_t;

   state_t             state, state_nxt;
   logic [15:0]        pc;
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [CNT_W-1:0]   count;
   logic [31:0]        instr_mem [DEPTH];
   logic [15:0]        pc_mem    [DEPTH];
   logic               fetch_en, pop, push, halt_word, not_empty;

   assign im_addr   = pc;
   assign fetch_en  = (state == RUN);
   assign not_empty = (count != '0);

`ifdef FETCH_HALT_EN
   assign halt_word = (im_data[31:28] == 4'hF);
   assign halted    = (state == HALT);
`else
   assign halt_word = 1'b0;
   assign halted    = 1'b0;
`endif

   // A redirect voids the handshake, so valid is masked in the same cycle.
   assign out_valid = not_empty & ~redirect;
   assign pop       = out_valid & out_ready;
   assign push      = ~redirect & fetch_en & ((count != CNT_W'(DEPTH)) | pop);
   assign out_instr = not_empty ? instr_mem[rd_ptr] : 32'h0;
   assign out_pc    = not_empty ? pc_mem[rd_ptr]    : 16'h0;

   always_comb begin
      state_nxt = state;
      if (redirect)
         state_nxt = RUN;
      else if (push && halt_word)
         state_nxt = HALT;
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state  <= RUN;
         pc     <= RESET_PC;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         state <= state_nxt;
         if (redirect) begin
            pc     <= redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            // A halting word is queued but the PC parks on it.
            if (push && !halt_word)
               pc <= pc + 16'd1;
            if (push)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
               count <= count + 1'b1;
            else if (pop && !push)
               count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= im_data;
         pc_mem[wr_ptr]    <= pc;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus queues expected {pc, instr} pairs, a monitor checks each handshake.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst_f;
   logic [15:0] im_addr;
   logic [31:0] im_data;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [15:0] out_pc;
   logic        halted;
   logic        halt_mode = 1'b0;

   typedef struct packed {
      logic [15:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   pops   = 0;
   int   p0;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_f(rst_f), .im_addr(im_addr), .im_data(im_data),
      .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
   );

   function automatic logic [31:0] mem_word(input logic [15:0] a, input logic hm);
      if (hm && a == 16'h0003)
         return 32'hF000_0000;
      return 32'h1000_0000 + {16'h0000, a};
   endfunction

   assign im_data = mem_word(im_addr, halt_mode);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_pc(input logic [15:0] p);
      exp_q.push_back({p, mem_word(p, halt_mode)});
   endtask

   // Monitor: every accepted handshake must match the head of the scoreboard.
   always @(negedge clk) begin
      ent_t e;
      if (rst_f && out_valid && out_ready) begin
         pops++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got pc %h expected none", out_pc);
         end else begin
            e = exp_q.pop_front();
            check("pop_pc", {16'h0, out_pc}, {16'h0, e.pc});
            check("pop_instr", out_instr, e.instr);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_f       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      out_ready   = 1'b0;
      tick();
      tick();
      check("rst_valid", {31'h0, out_valid}, 32'h0);
      check("rst_im_addr", {16'h0, im_addr}, 32'h0);
      check("rst_out_pc", {16'h0, out_pc}, 32'h0);
      check("rst_out_instr", out_instr, 32'h0);
      check("rst_halted", {31'h0, halted}, 32'h0);

      rst_f = 1'b1;
      tick();
      check("first_valid", {31'h0, out_valid}, 32'h1);
      check("first_pc", {16'h0, out_pc}, 32'h0);

      // Backpressure then streaming at one entry per cycle.
      repeat (4) tick();
      check("bp_im_addr", {16'h0, im_addr}, 32'h2);
      check("bp_out_pc", {16'h0, out_pc}, 32'h0);
      check("bp_out_instr", out_instr, 32'h1000_0000);
      check("bp_valid", {31'h0, out_valid}, 32'h1);
      for (int i = 0; i < 8; i++) expect_pc(16'(i));
      p0 = pops;
      out_ready = 1'b1;
      repeat (8) tick();
      out_ready = 1'b0;
      check("stream_pops", pops - p0, 32'd8);
      check("stream_drained", exp_q.size(), 32'd0);
      tick();
      check("full_im_addr", {16'h0, im_addr}, 32'h000A);
      check("full_out_pc", {16'h0, out_pc}, 32'h0008);
      check("run_halted", {31'h0, halted}, 32'h0);

      // Asynchronous reset with a full queue.
      rst_f = 1'b0;
      #1;
      check("async_valid", {31'h0, out_valid}, 32'h0);
      check("async_im_addr", {16'h0, im_addr}, 32'h0);
      check("async_out_pc", {16'h0, out_pc}, 32'h0);
      tick();
      rst_f = 1'b1;
      #1;
      check("release_valid", {31'h0, out_valid}, 32'h0);
      tick();
      check("release_valid2", {31'h0, out_valid}, 32'h1);
      check("release_pc", {16'h0, out_pc}, 32'h0);

      // Redirect coinciding with a ready head discards it.
      expect_pc(16'h0000);
      out_ready = 1'b1;
      tick();
      redirect    = 1'b1;
      redirect_pc = 16'h0040;
      #1;
      check("redir_valid_masked", {31'h0, out_valid}, 32'h0);
      tick();
      redirect = 1'b0;
      #1;
      check("redir_empty", {31'h0, out_valid}, 32'h0);
      check("redir_im_addr", {16'h0, im_addr}, 32'h0040);
      expect_pc(16'h0040);
      expect_pc(16'h0041);
      tick();
      check("redir_valid", {31'h0, out_valid}, 32'h1);
      check("redir_pc", {16'h0, out_pc}, 32'h0040);
      tick();
      tick();
      out_ready = 1'b0;
      check("redir_drained", exp_q.size(), 32'd0);

      // PC wrap from FFFF to 0000.
      redirect    = 1'b1;
      redirect_pc = 16'hFFFF;
      tick();
      redirect  = 1'b0;
      out_ready = 1'b1;
      expect_pc(16'hFFFF);
      expect_pc(16'h0000);
      expect_pc(16'h0001);
      tick();
      check("wrap_im_addr", {16'h0, im_addr}, 32'h0000);
      repeat (3) tick();
      out_ready = 1'b0;
      check("wrap_drained", exp_q.size(), 32'd0);

`ifdef FETCH_HALT_EN
      redirect    = 1'b1;
      redirect_pc = 16'h0000;
      tick();
      redirect  = 1'b0;
      halt_mode = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) expect_pc(16'(i));
      repeat (8) tick();
      check("halt_halted", {31'h0, halted}, 32'h1);
      check("halt_im_addr", {16'h0, im_addr}, 32'h0003);
      check("halt_no_valid", {31'h0, out_valid}, 32'h0);
      check("halt_drained", exp_q.size(), 32'd0);
      out_ready   = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 16'h0010;
      tick();
      redirect = 1'b0;
      check("resume_halted", {31'h0, halted}, 32'h0);
      check("resume_im_addr", {16'h0, im_addr}, 32'h0010);
      tick();
      check("resume_valid", {31'h0, out_valid}, 32'h1);
      check("resume_pc", {16'h0, out_pc}, 32'h0010);
`else
      check("end_halted", {31'h0, halted}, 32'h0);
`endif

      tick();
      check("final_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
